i2c_txn_scheduler: RTL and testbench

- Sequences complete I2C transactions for two independent requesters over one shared byte-level I2C master engine.
- Arbitrates round-robin, then issues START, address, data and STOP commands to the engine.
- Targets the 4-register I2C slave peripheral; supports 1–4 byte burst write/read per transaction.
- Sits between AXI-Lite-side request logic (or firmware FSMs) and the I2C master bit engine.

---
 rtl/i2c_sched_pkg.sv | 33 +++
 rtl/rr_arbiter2.sv | 26 ++
 rtl/i2c_txn_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_txn_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_sched_pkg.sv
// Shared command/state encodings and transaction record for the I2C
// transaction scheduler.
package i2c_sched_pkg;

   localparam int MAX_BYTES = 4;

   typedef enum logic [1:0] {
      CMD_START = 2'd0,
      CMD_WRITE = 2'd1,
      CMD_READ  = 2'd2,
      CMD_STOP  = 2'd3
   } cmd_e;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_ADDR, S_DATA, S_STOP, S_RESP
   } state_e;

   typedef enum logic {PH_ISSUE, PH_WAIT} phase_e;

   typedef struct packed {
      logic                   id;
      logic                   rw;
      logic [6:0]             addr;
      logic [1:0]             len;
      logic [8*MAX_BYTES-1:0] wdata;
   } txn_t;

   function automatic logic [7:0] byte_sel(input logic [8*MAX_BYTES-1:0] w,
                                           input logic [1:0] k);
      return w[{k, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, last winner remembered only
// when the grant is actually taken (en_i).
module rr_arbiter2
   import i2c_sched_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [1:0] req_i,
   input  logic       en_i,
   output logic [1:0] gnt_o
);

   logic last_q;

   always_comb begin
      gnt_o = req_i;
      if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
   end

   // Resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk_i) begin
      if (reset_i)                last_q <= 1'b1;
      else if (en_i && |gnt_o)    last_q <= gnt_o[1];
   end

endmodule

// File: rtl/i2c_txn_scheduler.sv
// Sequences START/ADDR/DATA/STOP for two round-robin requesters over one I2C
// byte engine. Define I2C_TXN_TIMEOUT_EN to add a per-command WAIT watchdog.
module i2c_txn_scheduler
   import i2c_sched_pkg::*;
`ifdef I2C_TXN_TIMEOUT_EN
   #(parameter int unsigned TIMEOUT_CYCLES = 65535)
`endif
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        req0_valid_i,
   output logic        req0_ready_o,
   input  logic        req0_rw_i,
   input  logic [6:0]  req0_addr_i,
   input  logic [1:0]  req0_len_i,
   input  logic [31:0] req0_wdata_i,
   input  logic        req1_valid_i,
   output logic        req1_ready_o,
   input  logic        req1_rw_i,
   input  logic [6:0]  req1_addr_i,
   input  logic [1:0]  req1_len_i,
   input  logic [31:0] req1_wdata_i,
   output logic        rsp_valid_o,
   output logic        rsp_id_o,
   output logic        rsp_nack_o,
   output logic [31:0] rsp_rdata_o,
`ifdef I2C_TXN_TIMEOUT_EN
   output logic        rsp_timeout_o,
`endif
   output logic        m_cmd_valid_o,
   input  logic        m_cmd_ready_i,
   output logic [1:0]  m_cmd_o,
   output logic [7:0]  m_tx_byte_o,
   output logic        m_rx_last_o,
   input  logic        m_done_i,
   input  logic        m_ack_rcvd_i,
   input  logic [7:0]  m_rx_byte_i
);

   state_e      state_q, state_d;
   phase_e      phase_q, phase_d;
   txn_t        txn_q, txn_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        nack_q, nack_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rdy_q, rdy_d;
   logic        rsp_id_q, rsp_id_d;
   logic        rsp_nack_q, rsp_nack_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
`ifdef I2C_TXN_TIMEOUT_EN
   logic [15:0] tmo_q, tmo_d;
   logic        tmo_hit_q, tmo_hit_d;
`endif

   logic [1:0] gnt;
   logic       cmd_st, issue_w, done_w, last_w;

   rr_arbiter2 u_arb (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .req_i   ({req1_valid_i, req0_valid_i}),
      .en_i    (state_q == S_IDLE),
      .gnt_o   (gnt)
   );

   assign cmd_st  = state_q inside {S_START, S_ADDR, S_DATA, S_STOP};
   assign issue_w = cmd_st && (phase_q == PH_ISSUE);
   // m_done outside a WAIT phase is deliberately dropped.
   assign done_w  = cmd_st && (phase_q == PH_WAIT) && m_done_i;
   assign last_w  = (cnt_q == txn_q.len);

   assign m_cmd_valid_o = issue_w;
   assign req0_ready_o  = rdy_q[0];
   assign req1_ready_o  = rdy_q[1];
   assign rsp_valid_o   = (state_q == S_RESP);
   assign rsp_id_o      = rsp_id_q;
   assign rsp_nack_o    = rsp_nack_q;
   assign rsp_rdata_o   = rsp_rdata_q;
`ifdef I2C_TXN_TIMEOUT_EN
   assign rsp_timeout_o = (state_q == S_RESP) && tmo_hit_q;
`endif

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      txn_d       = txn_q;
      cnt_d       = cnt_q;
      nack_d      = nack_q;
      rdata_d     = rdata_q;
      rdy_d       = 2'b00;
      rsp_id_d    = rsp_id_q;
      rsp_nack_d  = rsp_nack_q;
      rsp_rdata_d = rsp_rdata_q;
      m_cmd_o     = CMD_START;
      m_tx_byte_o = 8'h00;
      m_rx_last_o = 1'b0;

      if (issue_w && m_cmd_ready_i) phase_d = PH_WAIT;
      if (done_w)                   phase_d = PH_ISSUE;

      unique case (state_q)
         S_IDLE: begin
            if (|gnt) begin
               rdy_d       = gnt;
               txn_d.id    = gnt[1];
               txn_d.rw    = gnt[1] ? req1_rw_i    : req0_rw_i;
               txn_d.addr  = gnt[1] ? req1_addr_i  : req0_addr_i;
               txn_d.len   = gnt[1] ? req1_len_i   : req0_len_i;
               txn_d.wdata = gnt[1] ? req1_wdata_i : req0_wdata_i;
               cnt_d       = 2'd0;
               nack_d      = 1'b0;
               rdata_d     = 32'h0;
               phase_d     = PH_ISSUE;
               state_d     = S_START;
            end
         end
         S_START: begin
            if (done_w) state_d = S_ADDR;
         end
         S_ADDR: begin
            m_cmd_o     = CMD_WRITE;
            m_tx_byte_o = {txn_q.addr, txn_q.rw};
            if (done_w) begin
               if (!m_ack_rcvd_i) begin
                  nack_d  = 1'b1;
                  state_d = S_STOP;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (txn_q.rw) begin
               m_cmd_o     = CMD_READ;
               m_rx_last_o = last_w;
               if (done_w) begin
                  rdata_d[{cnt_q, 3'b000} +: 8] = m_rx_byte_i;
                  if (last_w) state_d = S_STOP;
                  else        cnt_d   = cnt_q + 2'd1;
               end
            end else begin
               m_cmd_o     = CMD_WRITE;
               m_tx_byte_o = byte_sel(txn_q.wdata, cnt_q);
               if (done_w) begin
                  if (!m_ack_rcvd_i) begin
                     nack_d  = 1'b1;
                     state_d = S_STOP;
                  end else if (last_w) begin
                     state_d = S_STOP;
                  end else begin
                     cnt_d = cnt_q + 2'd1;
                  end
               end
            end
         end
         S_STOP: begin
            m_cmd_o = CMD_STOP;
            if (done_w) begin
               state_d     = S_RESP;
               rsp_id_d    = txn_q.id;
               rsp_nack_d  = nack_q;
               rsp_rdata_d = rdata_q;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

`ifdef I2C_TXN_TIMEOUT_EN
      tmo_d     = tmo_q;
      tmo_hit_d = tmo_hit_q;
      if (issue_w && m_cmd_ready_i)
         tmo_d = 16'h0;
      else if (cmd_st && phase_q == PH_WAIT)
         tmo_d = tmo_q + 16'd1;
      if (state_q == S_STOP && done_w) tmo_hit_d = 1'b0;
      // Hung engine: skip STOP and report straight away.
      if (cmd_st && phase_q == PH_WAIT && !m_done_i &&
          tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
         state_d     = S_RESP;
         phase_d     = PH_ISSUE;
         rsp_id_d    = txn_q.id;
         rsp_nack_d  = 1'b1;
         rsp_rdata_d = rdata_q;
         tmo_hit_d   = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         phase_q     <= PH_ISSUE;
         txn_q       <= '0;
         cnt_q       <= 2'd0;
         nack_q      <= 1'b0;
         rdata_q     <= 32'h0;
         rdy_q       <= 2'b00;
         rsp_id_q    <= 1'b0;
         rsp_nack_q  <= 1'b0;
         rsp_rdata_q <= 32'h0;
`ifdef I2C_TXN_TIMEOUT_EN
         tmo_q       <= 16'h0;
         tmo_hit_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         txn_q       <= txn_d;
         cnt_q       <= cnt_d;
         nack_q      <= nack_d;
         rdata_q     <= rdata_d;
         rdy_q       <= rdy_d;
         rsp_id_q    <= rsp_id_d;
         rsp_nack_q  <= rsp_nack_d;
         rsp_rdata_q <= rsp_rdata_d;
`ifdef I2C_TXN_TIMEOUT_EN
         tmo_q       <= tmo_d;
         tmo_hit_q   <= tmo_hit_d;
`endif
      end
   end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Randomized bench for i2c_txn_scheduler: behavioural engine model plus a
// transaction-level reference for command stream, grant order and response.
module tb_i2c_txn_scheduler;
   import i2c_sched_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic        rq_rw [2];
   logic [6:0]  rq_addr [2];
   logic [1:0]  rq_len [2];
   logic [31:0] rq_wd [2];
   logic        rsp_valid, rsp_id, rsp_nack;
   logic [31:0] rsp_rdata;
   logic        m_cmd_valid, m_cmd_ready, m_rx_last, m_done, m_ack;
   logic [1:0]  m_cmd;
   logic [7:0]  m_tx_byte, m_rx;
`ifdef I2C_TXN_TIMEOUT_EN
   logic        rsp_timeout;
`endif

   i2c_txn_scheduler dut (
      .clk_i(clk), .reset_i(reset),
      .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_rw_i(rq_rw[0]),
      .req0_addr_i(rq_addr[0]), .req0_len_i(rq_len[0]), .req0_wdata_i(rq_wd[0]),
      .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_rw_i(rq_rw[1]),
      .req1_addr_i(rq_addr[1]), .req1_len_i(rq_len[1]), .req1_wdata_i(rq_wd[1]),
      .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_nack_o(rsp_nack),
      .rsp_rdata_o(rsp_rdata),
`ifdef I2C_TXN_TIMEOUT_EN
      .rsp_timeout_o(rsp_timeout),
`endif
      .m_cmd_valid_o(m_cmd_valid), .m_cmd_ready_i(m_cmd_ready), .m_cmd_o(m_cmd),
      .m_tx_byte_o(m_tx_byte), .m_rx_last_o(m_rx_last), .m_done_i(m_done),
      .m_ack_rcvd_i(m_ack), .m_rx_byte_i(m_rx)
   );

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return {15'h0, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_nack, rsp_rdata,
              m_cmd_valid, m_cmd, m_tx_byte, m_rx_last};
   endfunction

   function automatic int enc(input logic [1:0] c, input logic [7:0] b, input logic l);
      return int'({c, b, l});
   endfunction

   // Engine model state: per-transaction ACK plan (index 0 = address byte)
   // and read-byte plan, consumed in command order.
   bit         ack_plan [5];
   logic [7:0] rx_plan [4];
   int         wr_idx, rd_idx, hang_idx = -1, rdy_cnt = 0;
   int         cmd_log [$];

   initial begin
      bit         hs, busy, p_ack, p_hang;
      int         dly;
      logic [7:0] p_rx;
      logic [10:0] e;
      m_cmd_ready = 0; m_done = 0; m_ack = 0; m_rx = 0;
      busy = 0; p_hang = 0; p_ack = 0; p_rx = 0; dly = 0;
      forever begin
         @(negedge clk);
         rdy_cnt += int'(req0_ready) + int'(req1_ready);
         hs = m_cmd_valid && m_cmd_ready && !reset;
         if (hs) begin
            e = {m_cmd, (m_cmd == CMD_WRITE) ? m_tx_byte : 8'h00,
                 (m_cmd == CMD_READ) ? m_rx_last : 1'b0};
            p_hang = (cmd_log.size() == hang_idx);
            cmd_log.push_back(int'(e));
            p_ack = 0;
            p_rx  = 8'($urandom);
            if (m_cmd == CMD_WRITE) begin
               p_ack = (wr_idx < 5) ? ack_plan[wr_idx] : 1'b1;
               wr_idx++;
            end
            if (m_cmd == CMD_READ) begin
               p_rx = (rd_idx < 4) ? rx_plan[rd_idx] : 8'hEE;
               rd_idx++;
            end
            dly = $urandom_range(0, 3);
         end
         @(posedge clk); #1;
         m_done = 0;
         if (reset) begin
            busy = 0; m_cmd_ready = 0;
         end else begin
            if (hs) begin busy = 1; m_cmd_ready = 0; end
            if (busy) begin
               if (!p_hang) begin
                  if (dly == 0) begin
                     m_done = 1; m_ack = p_ack; m_rx = p_rx; busy = 0;
                  end else dly--;
               end
            end else begin
               m_cmd_ready = ($urandom_range(0, 2) != 0);
               // stray done outside WAIT must be ignored by the DUT
               if ($urandom_range(0, 7) == 0) begin
                  m_done = 1; m_ack = 0; m_rx = 8'($urandom);
               end
            end
         end
      end
   end

   int mlast = 1;

   task automatic rand_plan();
      for (int i = 0; i < 5; i++) ack_plan[i] = ($urandom_range(0, 5) != 0);
      for (int i = 0; i < 4; i++) rx_plan[i] = 8'($urandom);
   endtask

   task automatic run_txn(input bit v0, input bit v1, input bit rnd);
      int          g, n, exp_q[$];
      bit          got, enk;
      logic [31:0] erd, wd;
      logic [7:0]  ab;
      if (rnd) rand_plan();
      wr_idx = 0; rd_idx = 0; rdy_cnt = 0;
      cmd_log.delete();
      g = (v0 && v1) ? ((mlast == 0) ? 1 : 0) : (v1 ? 1 : 0);
      mlast = g;
      // reference: command stream and response from the transaction rules
      exp_q.push_back(enc(CMD_START, 8'h00, 1'b0));
      ab = {rq_addr[g], rq_rw[g]};
      exp_q.push_back(enc(CMD_WRITE, ab, 1'b0));
      enk = !ack_plan[0];
      erd = 32'h0;
      wd  = rq_wd[g];
      if (!enk) begin
         for (int k = 0; k <= int'(rq_len[g]); k++) begin
            if (rq_rw[g]) begin
               exp_q.push_back(enc(CMD_READ, 8'h00, k == int'(rq_len[g])));
               erd[8*k +: 8] = rx_plan[k];
            end else begin
               exp_q.push_back(enc(CMD_WRITE, wd[8*k +: 8], 1'b0));
               if (!ack_plan[k+1]) begin enk = 1; break; end
            end
         end
      end
      exp_q.push_back(enc(CMD_STOP, 8'h00, 1'b0));

      req0_valid = v0; req1_valid = v1;
      n = 0; got = 0;
      while (!got && n < 60) begin
         @(negedge clk); n++;
         got = req0_ready || req1_ready;
      end
      chk("grant_seen", 64'(got), 64'd1);
      if (!got) begin req0_valid = 0; req1_valid = 0; return; end
      chk("grant_id", {62'h0, req1_ready, req0_ready}, (g == 1) ? 64'd2 : 64'd1);
      if (g == 1) req1_valid = 0; else req0_valid = 0;
      @(negedge clk);
      chk("rdy_pulse", 64'(req0_ready || req1_ready), 64'd0);
      n = 0; got = 0;
      while (!got && n < 400) begin
         got = rsp_valid;
         if (!got) begin @(negedge clk); n++; end
      end
      chk("rsp_seen", 64'(got), 64'd1);
      if (!got) begin req0_valid = 0; req1_valid = 0; return; end
      chk("rsp_id", 64'(rsp_id), 64'(g));
      chk("rsp_nack", 64'(rsp_nack), 64'(enk));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(erd));
      chk("n_cmds", 64'(cmd_log.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++)
         chk($sformatf("cmd%0d", i), 64'(cmd_log[i]), 64'(exp_q[i]));
      chk("one_grant", 64'(rdy_cnt), 64'd1);
      @(negedge clk);
      chk("rsp_pulse", 64'(rsp_valid), 64'd0);
   endtask

   initial begin
      bit [1:0] mask;
      int       n;
      reset = 1; req0_valid = 0; req1_valid = 0;
      for (int i = 0; i < 2; i++) begin
         rq_rw[i] = 0; rq_addr[i] = 0; rq_len[i] = 0; rq_wd[i] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_outs", outs(), 64'h0);
      @(posedge clk); #1 reset = 0;

      // burst write, all ACK
      for (int i = 0; i < 5; i++) ack_plan[i] = 1;
      rq_rw[0] = 0; rq_addr[0] = 7'h55; rq_len[0] = 2'd3; rq_wd[0] = 32'hDDCCBBAA;
      run_txn(1, 0, 0);
      // two-byte read from requester 1
      rx_plan[0] = 8'h12; rx_plan[1] = 8'h34;
      rq_rw[1] = 1; rq_addr[1] = 7'h55; rq_len[1] = 2'd1;
      run_txn(0, 1, 0);
      chk("read_rdata", 64'(rsp_rdata), 64'h3412);
      // address NACK
      ack_plan[0] = 0;
      rq_rw[0] = 0; rq_addr[0] = 7'h22; rq_len[0] = 2'd2;
      run_txn(1, 0, 0);
      // both requesters held: alternating grants
      for (int i = 0; i < 5; i++) ack_plan[i] = 1;
      repeat (3) run_txn(1, 1, 0);
      req0_valid = 0; req1_valid = 0;

      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 2; i++) begin
            rq_rw[i] = 1'($urandom); rq_addr[i] = 7'($urandom);
            rq_len[i] = 2'($urandom); rq_wd[i] = $urandom;
         end
         mask = 2'($urandom_range(1, 3));
         run_txn(mask[0], mask[1], 1);
      end
      req0_valid = 0; req1_valid = 0;

      // reset while the first data WRITE hangs in WAIT
      for (int i = 0; i < 5; i++) ack_plan[i] = 1;
      rq_rw[0] = 0; rq_addr[0] = 7'h33; rq_len[0] = 2'd3; rq_wd[0] = 32'h44332211;
      wr_idx = 0; rd_idx = 0; hang_idx = 2;
      cmd_log.delete();
      req0_valid = 1;
      n = 0;
      while (cmd_log.size() < 3 && n < 200) begin @(negedge clk); n++; end
      chk("rst_reach", 64'(cmd_log.size()), 64'd3);
      repeat (2) @(negedge clk);
      chk("mid_busy", 64'(m_cmd_valid || rsp_valid), 64'd0);
      @(posedge clk); #1 reset = 1; req0_valid = 0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_outs", outs(), 64'h0);
      @(posedge clk); #1 reset = 0; hang_idx = -1; mlast = 1;
      run_txn(1, 1, 1);
      req0_valid = 0; req1_valid = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
